// File: rtl/sub_serial4.sv
// Serial subtractor: D = A - B - B0, one 4-bit slice per clock, LSB first,
// with the borrow carried between slices in a register.
module sub_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout,
  output logic       c3
);
  logic [4:0] s;
  logic [3:0] lo;
  // a - b - bin done as a + ~b + ~bin; lo exposes the carry into bit 3
  assign s    = {1'b0, a} + {1'b0, ~b} + {4'b0, ~bin};
  assign lo   = {1'b0, a[2:0]} + {1'b0, ~b[2:0]} + {3'b0, ~bin};
  assign d    = s[3:0];
  assign bout = ~s[4];
  assign c3   = lo[3];
endmodule

module sub_serial4 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r, shadow;
  logic             borrow;
  logic [IW-1:0]    idx;

  logic [3:0]       sl_d;
  logic             sl_bout, sl_c3;
  logic [WIDTH+3:0] cat;
  logic [WIDTH-1:0] shadow_nx;

  // Operands shift right one slice per edge so the slice is always bits [3:0]
  sub_slice4 u_slice (
    .a   (a_r[3:0]),
    .b   (b_r[3:0]),
    .bin (borrow),
    .d   (sl_d),
    .bout(sl_bout),
    .c3  (sl_c3)
  );

  // New slice enters at the top; after N edges the shadow is fully aligned
  assign cat       = {sl_d, shadow};
  assign shadow_nx = cat[WIDTH+3:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      shadow <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      D      <= '0;
      Bout   <= 1'b0;
      V      <= 1'b0;
      Z      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r    <= A;
            b_r    <= B;
            borrow <= B0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_r    <= a_r >> 4;
          b_r    <= b_r >> 4;
          borrow <= sl_bout;
          shadow <= shadow_nx;
          if (idx == IW'(N - 1)) begin
            D     <= shadow_nx;
            Bout  <= sl_bout;
            V     <= sl_c3 ^ ~sl_bout;
            Z     <= (shadow_nx == '0);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sub_serial4.sv
// Bench for sub_serial4 (WIDTH=16): directed table, handshake corner cases,
// and random operations checked against an arithmetic reference model.
module tb_sub_serial4;
  localparam int W = 16;

  logic         clk = 0, rst_n = 0, start = 0, b0 = 0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, bout, v, z;
  logic [W-1:0] d;

  int n_cmp = 0, n_err = 0;

  sub_serial4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .B0(b0),
    .busy(busy), .done(done), .D(d), .Bout(bout), .V(v), .Z(z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic         b0;
    logic [W-1:0] d;
    logic         bout, v, z;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mb0);
    vec_t m;
    int diff, sd;
    diff = int'(ma) - int'(mb) - int'(mb0);
    sd   = int'($signed(ma)) - int'($signed(mb)) - int'(mb0);
    m.a = ma; m.b = mb; m.b0 = mb0;
    m.d    = diff[W-1:0];
    m.bout = (diff < 0);
    m.v    = (sd > 32767) || (sd < -32768);
    m.z    = (m.d == '0);
    return m;
  endfunction

  task automatic chk_res(input string name, input vec_t e);
    chk({name, ".D"},    32'(d),    32'(e.d));
    chk({name, ".Bout"}, 32'(bout), 32'(e.bout));
    chk({name, ".V"},    32'(v),    32'(e.v));
    chk({name, ".Z"},    32'(z),    32'(e.z));
  endtask

  // Waits (bounded) for done from the negedge after the accepting edge.
  task automatic wait_done(input string name, output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    chk({name, ".done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic run_op(input string name, input vec_t e, input logic [W-1:0] prev_d, input bit timing);
    int lat, nb;
    a = e.a; b = e.b; b0 = e.b0; start = 1;
    @(negedge clk);
    start = 0; a = $urandom; b = $urandom; b0 = $urandom;
    chk({name, ".held_D"}, 32'(d), 32'(prev_d));
    wait_done(name, lat, nb);
    if (timing) begin
      chk({name, ".latency"}, 32'(lat), 32'd4);
      chk({name, ".busy_cycles"}, 32'(nb), 32'd4);
      chk({name, ".busy_at_done"}, 32'(busy), 32'd0);
    end
    chk_res(name, e);
    @(negedge clk);
    chk({name, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    vec_t e, e2;
    int lat, nb;
    logic [W-1:0] last_d;

    tbl[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};

    #12;
    chk("reset.busy", 32'(busy), 0); chk("reset.done", 32'(done), 0);
    chk("reset.D", 32'(d), 0);       chk("reset.Bout", 32'(bout), 0);
    chk("reset.V", 32'(v), 0);       chk("reset.Z", 32'(z), 0);
    rst_n = 1;
    @(negedge clk);

    last_d = '0;
    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i], last_d, 1);
      last_d = tbl[i].d;
    end

    // start pulsed during RUN must be ignored
    e = model(16'hABCD, 16'h1234, 1'b0);
    a = e.a; b = e.b; b0 = e.b0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0001; start = 1;
    @(negedge clk);
    start = 0;
    chk("ign.D_unchanged", 32'(d), 32'(last_d));
    lat = 2;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("ign.latency", 32'(lat), 32'd4);
    chk_res("ign", e);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("ign.no_second", 32'(done | busy), 32'd0);
    end
    last_d = e.d;

    // start held through DONE: second op accepted back to back
    e  = model(16'h7FFF, 16'hFFFF, 1'b0);
    e2 = model(16'h0001, 16'h0002, 1'b1);
    a = e.a; b = e.b; b0 = e.b0; start = 1;
    @(negedge clk);
    a = e2.a; b = e2.b; b0 = e2.b0;
    wait_done("b2b1", lat, nb);
    chk("b2b1.latency", 32'(lat), 32'd4);
    chk_res("b2b1", e);
    @(negedge clk);
    start = 0;
    chk("b2b2.busy", 32'(busy), 32'd1);
    wait_done("b2b2", lat, nb);
    chk("b2b2.latency", 32'(lat), 32'd4);
    chk_res("b2b2", e2);
    @(negedge clk);

    // reset during RUN slice 2
    e = model(16'h1111, 16'h2222, 1'b0);
    a = e.a; b = e.b; b0 = e.b0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst.busy", 32'(busy), 0); chk("rst.done", 32'(done), 0);
    chk("rst.D", 32'(d), 0);       chk("rst.Bout", 32'(bout), 0);
    chk("rst.V", 32'(v), 0);       chk("rst.Z", 32'(z), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst.stays_idle", 32'(busy | done), 0);
    run_op("post_rst", e, 16'h0000, 1);
    last_d = e.d;

    // random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      e = model(W'($urandom), W'($urandom), 1'($urandom));
      if (i % 8 == 0) e = model(e.a, e.a, 1'b0);
      run_op($sformatf("rnd%0d", i), e, last_d, (i % 5 == 0));
      last_d = e.d;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
